mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 256, memory line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk_i in 1 (rising-edge clock); rst_i in 1 (synchronous active-high reset).
REQ-004 SHALL have, for requesters n=0 (icache) and n=1 (dcache): reqn_enable_i in 1 (request valid, held until ack); reqn_write_i in 1 (1=write line); reqn_addr_i in ADDR_W (line address); reqn_data_i in DATA_W (write line).
REQ-005 SHALL have, per requester: reqn_ack_o out 1 (one-cycle completion pulse); reqn_data_o out DATA_W (read line, valid when ack).
REQ-006 SHALL have memory-side ports: mem_enable_o out 1 (access request); mem_write_o out 1; mem_addr_o out ADDR_W; mem_data_o out DATA_W; mem_data_i in DATA_W (read line); mem_ack_i in 1 (one-cycle access completion).
REQ-007 SHALL have busy_o out 1: state is not IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-009 IDLE: with no enable asserted, SHALL stay IDLE.
REQ-010 IDLE: with any enable asserted, SHALL select a winner, latch its write/addr/data into registers, record grant index gnt, and go to BUSY next cycle.
REQ-011 Arbitration SHALL be round-robin on a 1-bit last-grant register: a sole requester wins; if both request, the port not granted last wins.
REQ-012 The last-grant register SHALL update on grant only.
REQ-013 BUSY: mem_enable_o SHALL be 1, with mem_write_o/mem_addr_o/mem_data_o driven from the latched registers. Requester inputs changing during BUSY SHALL have no effect.
REQ-014 BUSY: with mem_ack_i=1, SHALL latch mem_data_i into a DATA_W read register and go to DONE; otherwise SHALL stay in BUSY with no timeout.
REQ-015 DONE: reqgnt_ack_o SHALL be 1 for exactly this cycle and mem_enable_o SHALL be 0; next state is IDLE unconditionally.
REQ-016 reqn_data_o SHALL both equal the read register; it is meaningful only during ack of a read. For writes, the read register value is don't-care but SHALL still be latched.
REQ-017 The non-granted ack SHALL be 0 at all times.
REQ-018 Requesters SHALL drop enable the cycle after ack; IDLE after DONE SHALL therefore re-arbitrate fresh requests. A requester holding enable is served again; a waiting other port wins by round-robin.
REQ-019 Worst-case latency, enable to ack, SHALL be 1 (IDLE) + 1 (BUSY, minimum) + memory wait + 1 (DONE). For a memory acking in its first BUSY cycle this is 3 cycles.
REQ-020 A mem_ack_i outside BUSY SHALL be ignored, with no state change and no ack.
REQ-021 All outputs SHALL be registered or decoded from state/registers only, with no combinational path from reqn_* or mem_ack_i to any output.

Reset
REQ-022 On rst_i=1 at a clock edge, SHALL enter IDLE and clear: mem_enable_o, mem_write_o, both acks, busy_o, last-grant (=1, so port 0 wins first tie).
REQ-023 On rst_i=1 at a clock edge, SHALL clear the address/data/read registers to 0.
REQ-024 Reset mid-BUSY SHALL abandon the transaction with no ack. A subsequent stray mem_ack_i SHALL be ignored per REQ-020.

Verification
REQ-025 Single read: req1_enable_i=1, write=0, addr=0x0000_0040; memory acks on the 3rd BUSY cycle with data 256'hA5..A5 -> mem_enable_o high for 3 cycles, mem_addr_o=0x40, req1_ack_o pulses once with req1_data_o=A5..A5, req0_ack_o stays 0.
REQ-026 Tie after reset: both enables high simultaneously -> port 0 served first. Port 1 is granted on the IDLE after port 0's DONE, with addr/data/write of port 1 on the memory bus.
REQ-027 Round-robin: both ports keep re-requesting for 6 transactions -> grants alternate 0,1,0,1,0,1 and no port is served twice consecutively.
REQ-028 Write: req0_write_i=1, addr=0x100, data=256'h1234; inputs changed to garbage during BUSY -> mem_write_o=1, mem_addr_o=0x100, mem_data_o=0x1234 stable until mem_ack_i; req0_ack_o pulses.
REQ-029 Reset mid-BUSY, then mem_ack_i=1 one cycle after reset -> no ack on either port; state IDLE; mem_enable_o=0.
REQ-030 Stray mem_ack_i=1 in IDLE with no requests -> no output change; busy_o remains 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that serialises icache/dcache line requests onto
// a single memory port. Each request is served as IDLE -> BUSY -> DONE.
module mem_arbiter #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_enable_i,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ack_o,
    output logic [DATA_W-1:0] req0_data_o,

    input  logic              req1_enable_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ack_o,
    output logic [DATA_W-1:0] req1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last;
    logic                r_gnt;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_mem_enable;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_busy;
    logic                w_gnt;

    // On a tie the port not granted last wins; otherwise the sole requester.
    assign w_gnt = (req0_enable_i & req1_enable_i) ? ~r_last : req1_enable_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_gnt        <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_mem_enable <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0_enable_i | req1_enable_i) begin
                        r_gnt        <= w_gnt;
                        r_last       <= w_gnt;
                        r_write      <= w_gnt ? req1_write_i : req0_write_i;
                        r_addr       <= w_gnt ? req1_addr_i  : req0_addr_i;
                        r_wdata      <= w_gnt ? req1_data_i  : req0_data_i;
                        r_mem_enable <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        r_rdata      <= mem_data_i;
                        r_mem_enable <= 1'b0;
                        r_ack0       <= ~r_gnt;
                        r_ack1       <= r_gnt;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_mem_enable <= 1'b0;
                    r_ack0       <= 1'b0;
                    r_ack1       <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign req0_ack_o   = r_ack0;
    assign req1_ack_o   = r_ack1;
    assign req0_data_o  = r_rdata;
    assign req1_data_o  = r_rdata;
    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_write;
    assign mem_addr_o   = r_addr;
    assign mem_data_o   = r_wdata;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level
// model: per-port pending requests, round-robin rule and a sparse memory.
module tb_mem_arbiter;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned ADDR_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              en   [2];
    logic              wr   [2];
    logic [ADDR_W-1:0] ad   [2];
    logic [DATA_W-1:0] dt   [2];
    logic              ack0, ack1;
    logic [DATA_W-1:0] dout0, dout1;
    logic              mem_enable_o, mem_write_o, busy_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit                pend [2];
    bit                pw   [2];
    logic [ADDR_W-1:0] pa   [2];
    logic [DATA_W-1:0] pd   [2];
    int                last;
    logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req0_enable_i (en[0]),
        .req0_write_i  (wr[0]),
        .req0_addr_i   (ad[0]),
        .req0_data_i   (dt[0]),
        .req0_ack_o    (ack0),
        .req0_data_o   (dout0),
        .req1_enable_i (en[1]),
        .req1_write_i  (wr[1]),
        .req1_addr_i   (ad[1]),
        .req1_data_i   (dt[1]),
        .req1_ack_o    (ack1),
        .req1_data_o   (dout1),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .busy_o        (busy_o)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, required finish before 200us");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_line();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] default_line(input logic [ADDR_W-1:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic req(input int p, input bit w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
        pend[p] = 1'b1; pw[p] = w; pa[p] = a; pd[p] = d;
        en[p] = 1'b1;   wr[p] = w; ad[p] = a; dt[p] = d;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        en[0] = 1'b0; en[1] = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        mem_ack_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        last = 1;
    endtask

    // One full transaction from IDLE (requests already presented) back to IDLE.
    task automatic run_txn(input int waits, input bit garble);
        int w;
        logic [DATA_W-1:0] rd;
        w = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
        tick();
        check("busy_start", busy_o, 1'b1);
        check("mem_en_start", mem_enable_o, 1'b1);
        check("mem_wr", mem_write_o, pw[w]);
        check("mem_addr", mem_addr_o, pa[w]);
        check("mem_data", mem_data_o, pd[w]);
        check("ack_busy", {ack1, ack0}, 2'b00);
        for (int i = 0; i < waits; i++) begin
            if (garble) begin
                wr[w] = 1'($urandom_range(0, 1));
                ad[w] = $urandom();
                dt[w] = rnd_line();
            end
            mem_data_i = rnd_line();
            tick();
            check("mem_en_wait", mem_enable_o, 1'b1);
            check("mem_wr_hold", mem_write_o, pw[w]);
            check("mem_addr_hold", mem_addr_o, pa[w]);
            check("mem_data_hold", mem_data_o, pd[w]);
            check("ack_wait", {ack1, ack0}, 2'b00);
        end
        if (pw[w]) rd = rnd_line();
        else rd = mem_model.exists(pa[w]) ? mem_model[pa[w]] : default_line(pa[w]);
        mem_ack_i = 1'b1;
        mem_data_i = rd;
        tick();
        mem_ack_i = 1'b0;
        mem_data_i = rnd_line();
        check("ack_done", {ack1, ack0}, (w == 1) ? 2'b10 : 2'b01);
        check("mem_en_done", mem_enable_o, 1'b0);
        check("busy_done", busy_o, 1'b1);
        if (!pw[w]) begin
            check("rdata0", dout0, rd);
            check("rdata1", dout1, rd);
        end else begin
            mem_model[pa[w]] = pd[w];
        end
        tick();
        check("busy_idle", busy_o, 1'b0);
        check("ack_idle", {ack1, ack0}, 2'b00);
        check("mem_en_idle", mem_enable_o, 1'b0);
        last = w;
        pend[w] = 1'b0;
        en[w] = 1'b0;
    endtask

    initial begin
        en[0] = 1'b0; en[1] = 1'b0;
        wr[0] = 1'b0; wr[1] = 1'b0;
        ad[0] = '0;   ad[1] = '0;
        dt[0] = '0;   dt[1] = '0;
        mem_data_i = '0;
        mem_model[32'h40] = {32{8'hA5}};

        // Reset values
        do_reset();
        check("rst_busy", busy_o, 1'b0);
        check("rst_mem_en", mem_enable_o, 1'b0);
        check("rst_mem_wr", mem_write_o, 1'b0);
        check("rst_acks", {ack1, ack0}, 2'b00);
        check("rst_addr", mem_addr_o, '0);
        check("rst_wdata", mem_data_o, '0);
        check("rst_rdata", dout0, '0);

        // Stray memory ack in IDLE
        mem_ack_i = 1'b1;
        mem_data_i = rnd_line();
        tick();
        mem_ack_i = 1'b0;
        check("stray_busy", busy_o, 1'b0);
        check("stray_acks", {ack1, ack0}, 2'b00);
        check("stray_mem_en", mem_enable_o, 1'b0);
        tick();
        check("stray_busy2", busy_o, 1'b0);
        check("stray_rdata", dout1, '0);

        // Single read from dcache, memory acks on the third BUSY cycle
        req(1, 1'b0, 32'h0000_0040, '0);
        run_txn(2, 1'b0);

        // Tie after reset: port 0 then port 1
        do_reset();
        req(0, 1'b0, 32'h0000_0200, rnd_line());
        req(1, 1'b1, 32'h0000_0300, rnd_line());
        run_txn(0, 1'b0);
        check("tie_p1_waiting", busy_o, 1'b0);
        run_txn(1, 1'b0);

        // Both ports keep re-requesting
        req(0, 1'b0, 32'h0000_0300, '0);
        req(1, 1'b0, 32'h0000_0040, '0);
        for (int t = 0; t < 6; t++) begin
            run_txn(0, 1'b0);
            req(last, 1'b0, (last == 0) ? 32'h0000_0300 : 32'h0000_0040, '0);
        end
        en[0] = 1'b0; en[1] = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        tick();

        // Write with garbage on the inputs during BUSY
        req(0, 1'b1, 32'h0000_0100, DATA_W'(16'h1234));
        run_txn(3, 1'b1);
        req(1, 1'b0, 32'h0000_0100, '0);
        run_txn(0, 1'b0);

        // Reset mid-BUSY then a stray memory ack
        req(0, 1'b0, 32'h0000_0080, '0);
        tick();
        check("mid_busy", busy_o, 1'b1);
        tick();
        rst_i = 1'b1;
        en[0] = 1'b0;
        pend[0] = 1'b0;
        tick();
        rst_i = 1'b0;
        last = 1;
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_mem_en", mem_enable_o, 1'b0);
        check("mid_rst_addr", mem_addr_o, '0);
        mem_ack_i = 1'b1;
        mem_data_i = rnd_line();
        tick();
        mem_ack_i = 1'b0;
        check("post_rst_acks", {ack1, ack0}, 2'b00);
        check("post_rst_busy", busy_o, 1'b0);
        check("post_rst_mem_en", mem_enable_o, 1'b0);
        tick();
        check("post_rst_acks2", {ack1, ack0}, 2'b00);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1)
                    req(p, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7) * 32),
                        rnd_line());
            end
            if (!pend[0] && !pend[1])
                req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ADDR_W'($urandom_range(0, 7) * 32), rnd_line());
            run_txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
